pipe_control_unit: RTL and testbench

- Pipelined successor to the single-cycle RV32I decoder: decodes the instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six branch conditions in EX, generates flush/bubble behaviour and flags illegal encodings.
- Optional M-extension decode, plus a retired-instruction counter.
- Sits between the IF/ID register and the datapath/hazard unit of the 5-stage core.

---
 rtl/pipe_control_unit.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: RV32I control path for a 5-stage pipeline.
// The instruction in ID is decoded into a control bundle. The bundle then
// moves through the ID/EX, EX/MEM and MEM/WB registers. Branches are
// resolved in EX. Illegal or flushed slots turn into bubbles.
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   InstrD_i, ValidD_i  instruction in ID and its valid flag
//   FlushE_i            hazard unit request to load a bubble into ID/EX
//   ZeroE_i/LtE_i/LtuE_i ALU compare flags for the instruction in EX
//   ImmSrcD_o           immediate select (combinational, ID)
//   *E_o / *M_o / *W_o  control outputs of the EX, MEM and WB stages
//   PCSrcE_o            redirect taken (combinational, EX)
//   IllegalE_o          EX slot came from an illegal encoding
//   RetireCnt_o         count of instructions leaving WB
module pipe_control_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int M_EXT      = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] InstrD_i,
    input  logic                  ValidD_i,
    input  logic                  FlushE_i,
    input  logic                  ZeroE_i,
    input  logic                  LtE_i,
    input  logic                  LtuE_i,
    output logic [2:0]            ImmSrcD_o,
    output logic [3+M_EXT:0]      ALUCtrlE_o,
    output logic                  ALUSrcAE_o,
    output logic                  ALUSrcBE_o,
    output logic                  JalrE_o,
    output logic                  PCSrcE_o,
    output logic                  LoadE_o,
    output logic                  RegWriteE_o,
    output logic                  MemWriteM_o,
    output logic [1:0]            MemTypeM_o,
    output logic                  MemSignM_o,
    output logic                  RegWriteM_o,
    output logic [1:0]            ResultSrcW_o,
    output logic                  RegWriteW_o,
    output logic                  IllegalE_o,
    output logic [CNT_W-1:0]      RetireCnt_o
);
    localparam int AW = 4 + M_EXT;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    typedef struct packed {
        logic          valid;
        logic          illegal;
        logic          reg_write;
        logic [1:0]    result_src;
        logic          mem_write;
        logic [1:0]    mem_type;
        logic          mem_sign;
        logic          load;
        logic          branch;
        logic          jump;
        logic          jalr;
        logic          src_a;
        logic          src_b;
        logic [AW-1:0] alu_ctrl;
        logic [2:0]    funct3;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] mem_type;
        logic       mem_sign;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } mem_wb_t;

    // funct3 gives the base operation. alt picks SUB over ADD and SRA over SRL.
    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = 5'b01000;                 // SLL
            3'b010:  alu_of = 5'b00101;                 // SLT
            3'b011:  alu_of = 5'b00110;                 // SLTU
            3'b100:  alu_of = 5'b00100;                 // XOR
            3'b101:  alu_of = alt ? 5'b01001 : 5'b00111; // SRA : SRL
            3'b110:  alu_of = 5'b00011;                 // OR
            default: alu_of = 5'b00010;                 // AND
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = InstrD_i[6:0];
    assign funct3 = InstrD_i[14:12];
    assign funct7 = InstrD_i[31:25];

    // Register fields belong to the datapath and are not used here.
    logic unused_fields;
    assign unused_fields = ^{InstrD_i[24:15], InstrD_i[11:7]};

    id_ex_t  dec, id_ex_next, id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;
    logic    illegal;
    logic [4:0] alu_d;
    logic    take;

    // ---------------- ID: decode ----------------
    always_comb begin
        // NOTE: every signal gets a default first, so no latch is inferred
        // on the paths that leave a field alone.
        dec       = '0;
        illegal   = 1'b0;
        alu_d     = ALU_ADD;
        ImmSrcD_o = 3'b000;
        dec.valid  = 1'b1;
        dec.funct3 = funct3;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.load       = 1'b1;
                dec.src_b      = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_type = 2'b01;
                    3'b001:  dec.mem_type = 2'b10;
                    3'b010:  dec.mem_type = 2'b00;
                    3'b100:  begin dec.mem_type = 2'b01; dec.mem_sign = 1'b1; end
                    3'b101:  begin dec.mem_type = 2'b10; dec.mem_sign = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                // Only the right shift uses funct7[5]. addi never becomes SUB.
                alu_d = alu_of(funct3, funct7[5] && funct3 == 3'b101);
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    illegal = 1'b1;
            end
            OP_REG: begin
                dec.reg_write = 1'b1;
                alu_d = alu_of(funct3, funct7[5]);
                case (funct7)
                    7'b0000000: ;
                    7'b0100000: if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
                    7'b0000001: begin
                        if (M_EXT == 0) illegal = 1'b1;
                        else            alu_d = {1'b1, 1'b0, funct3};
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_AUIPC: begin
                ImmSrcD_o     = 3'b011;
                dec.reg_write = 1'b1;
                dec.src_a     = 1'b1;
                dec.src_b     = 1'b1;
            end
            OP_LUI: begin
                ImmSrcD_o     = 3'b011;
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                alu_d         = ALU_PASSB;
            end
            OP_STORE: begin
                ImmSrcD_o     = 3'b001;
                dec.mem_write = 1'b1;
                dec.src_b     = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_type = 2'b01;
                    3'b001:  dec.mem_type = 2'b10;
                    3'b010:  dec.mem_type = 2'b00;
                    default: illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                ImmSrcD_o  = 3'b010;
                dec.branch = 1'b1;
                alu_d      = ALU_SUB;
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jalr       = 1'b1;
                dec.src_b      = 1'b1;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OP_JAL: begin
                ImmSrcD_o      = 3'b100;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.src_a      = 1'b1;
                dec.src_b      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        dec.alu_ctrl = alu_d[AW-1:0];
    end

    // A redirect or flush always wins. It is followed by an invalid slot, then
    // an illegal marker, and only then the decoded bundle.
    always_comb begin
        id_ex_next = '0;
        if (PCSrcE_o || FlushE_i || !ValidD_i) begin
            id_ex_next = '0;
        end else if (illegal) begin
            id_ex_next.illegal = 1'b1;
        end else begin
            id_ex_next = dec;
        end
    end

    // ---------------- EX: branch resolution ----------------
    always_comb begin
        take = 1'b0;
        case (id_ex.funct3)
            3'b000:  take = ZeroE_i;
            3'b001:  take = !ZeroE_i;
            3'b100:  take = LtE_i;
            3'b101:  take = !LtE_i;
            3'b110:  take = LtuE_i;
            3'b111:  take = !LtuE_i;
            default: take = 1'b0;
        endcase
    end

    assign PCSrcE_o = id_ex.jump | id_ex.jalr | (id_ex.branch & take);

    // ---------------- pipeline registers ----------------
    // NOTE: these registers use non-blocking assignments. All three stages
    // therefore sample the old value of the stage before them on the same edge.
    // Reset loads a bubble everywhere, so anything in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
            RetireCnt_o <= '0;
        end else begin
            id_ex                <= id_ex_next;
            ex_mem.valid         <= id_ex.valid;
            ex_mem.reg_write     <= id_ex.reg_write;
            ex_mem.result_src    <= id_ex.result_src;
            ex_mem.mem_write     <= id_ex.mem_write;
            ex_mem.mem_type      <= id_ex.mem_type;
            ex_mem.mem_sign      <= id_ex.mem_sign;
            mem_wb.valid         <= ex_mem.valid;
            mem_wb.reg_write     <= ex_mem.reg_write;
            mem_wb.result_src    <= ex_mem.result_src;
            if (mem_wb.valid)
                RetireCnt_o <= RetireCnt_o + CNT_W'(1);
        end
    end

    assign ALUCtrlE_o   = id_ex.alu_ctrl;
    assign ALUSrcAE_o   = id_ex.src_a;
    assign ALUSrcBE_o   = id_ex.src_b;
    assign JalrE_o      = id_ex.jalr;
    assign LoadE_o      = id_ex.load;
    assign RegWriteE_o  = id_ex.reg_write;
    assign IllegalE_o   = id_ex.illegal;
    assign MemWriteM_o  = ex_mem.mem_write;
    assign MemTypeM_o   = ex_mem.mem_type;
    assign MemSignM_o   = ex_mem.mem_sign;
    assign RegWriteM_o  = ex_mem.reg_write;
    assign ResultSrcW_o = mem_wb.result_src;
    assign RegWriteW_o  = mem_wb.reg_write;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: self-checking bench for pipe_control_unit.
// u_dut (M_EXT=0, CNT_W=4) is checked stage by stage against a scoreboard.
// For each driven instruction, the control bundle expected in EX is queued.
// It is popped at the next edge and then shifted into MEM and WB copies.
// u_dut_m (M_EXT=1) receives the same stimulus and is used only for M decode.
module tb_pipe_control_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] InstrD_i = '0;
    logic        ValidD_i = 1'b0;
    logic        FlushE_i = 1'b0;
    logic        ZeroE_i = 1'b0;
    logic        LtE_i = 1'b0;
    logic        LtuE_i = 1'b0;

    always #20 clk = ~clk;

    logic [2:0] ImmSrcD_o;
    logic [3:0] ALUCtrlE_o;
    logic       ALUSrcAE_o, ALUSrcBE_o, JalrE_o, PCSrcE_o, LoadE_o, RegWriteE_o;
    logic       MemWriteM_o, MemSignM_o, RegWriteM_o, RegWriteW_o, IllegalE_o;
    logic [1:0] MemTypeM_o, ResultSrcW_o;
    logic [3:0] RetireCnt_o;

    logic [2:0]  imm_mx;
    logic [4:0]  alu_mx;
    logic        src_a_mx, src_b_mx, jalr_mx, pcsrc_mx, load_mx, rw_e_mx;
    logic        mw_m_mx, ms_m_mx, rw_m_mx, rw_w_mx, ill_mx;
    logic [1:0]  mt_m_mx, rs_w_mx;
    logic [31:0] cnt_mx;

    pipe_control_unit #(.DATA_WIDTH(32), .M_EXT(0), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .InstrD_i(InstrD_i), .ValidD_i(ValidD_i),
        .FlushE_i(FlushE_i), .ZeroE_i(ZeroE_i), .LtE_i(LtE_i), .LtuE_i(LtuE_i),
        .ImmSrcD_o(ImmSrcD_o), .ALUCtrlE_o(ALUCtrlE_o), .ALUSrcAE_o(ALUSrcAE_o),
        .ALUSrcBE_o(ALUSrcBE_o), .JalrE_o(JalrE_o), .PCSrcE_o(PCSrcE_o),
        .LoadE_o(LoadE_o), .RegWriteE_o(RegWriteE_o), .MemWriteM_o(MemWriteM_o),
        .MemTypeM_o(MemTypeM_o), .MemSignM_o(MemSignM_o), .RegWriteM_o(RegWriteM_o),
        .ResultSrcW_o(ResultSrcW_o), .RegWriteW_o(RegWriteW_o),
        .IllegalE_o(IllegalE_o), .RetireCnt_o(RetireCnt_o)
    );

    pipe_control_unit #(.DATA_WIDTH(32), .M_EXT(1), .CNT_W(32)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .InstrD_i(InstrD_i), .ValidD_i(ValidD_i),
        .FlushE_i(FlushE_i), .ZeroE_i(ZeroE_i), .LtE_i(LtE_i), .LtuE_i(LtuE_i),
        .ImmSrcD_o(imm_mx), .ALUCtrlE_o(alu_mx), .ALUSrcAE_o(src_a_mx),
        .ALUSrcBE_o(src_b_mx), .JalrE_o(jalr_mx), .PCSrcE_o(pcsrc_mx),
        .LoadE_o(load_mx), .RegWriteE_o(rw_e_mx), .MemWriteM_o(mw_m_mx),
        .MemTypeM_o(mt_m_mx), .MemSignM_o(ms_m_mx), .RegWriteM_o(rw_m_mx),
        .ResultSrcW_o(rs_w_mx), .RegWriteW_o(rw_w_mx),
        .IllegalE_o(ill_mx), .RetireCnt_o(cnt_mx)
    );

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] mem_type;
        logic       mem_sign;
        logic       load;
        logic       jalr;
        logic       src_a;
        logic       src_b;
        logic [3:0] alu;
    } ctl_t;

    ctl_t       exp_q[$];
    ctl_t       exp_ex, exp_mem, exp_wb;
    logic [3:0] exp_cnt;
    int         n_checks = 0;
    int         n_fail = 0;

    ctl_t bub_c, ill_c, add_c, addi_c, lw_c, lhu_c, sw_c, sb_c, br_c;
    ctl_t jal_c, jalr_c, lui_c, auipc_c, sub_c, sra_c, srai_c;

    function automatic ctl_t c(input logic rw, input logic [1:0] rs, input logic mw,
                               input logic [1:0] mt, input logic ms, input logic ld,
                               input logic jr, input logic sa, input logic sb,
                               input logic [3:0] alu);
        ctl_t r;
        r = '0;
        r.valid = 1'b1; r.reg_write = rw; r.result_src = rs; r.mem_write = mw;
        r.mem_type = mt; r.mem_sign = ms; r.load = ld; r.jalr = jr;
        r.src_a = sa; r.src_b = sb; r.alu = alu;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_ex = '0; exp_mem = '0; exp_wb = '0; exp_cnt = '0;
    endtask

    // Drive one ID slot, then compare every stage right after the next edge.
    task automatic step(input logic [31:0] instr, input logic valid, input logic flush,
                        input logic [2:0] imm, input ctl_t exp);
        InstrD_i = instr; ValidD_i = valid; FlushE_i = flush;
        exp_q.push_back(exp);
        #1 check("imm_src_d", 32'(ImmSrcD_o), 32'(imm));
        @(posedge clk);
        if (exp_wb.valid) exp_cnt++;
        exp_wb  = exp_mem;
        exp_mem = exp_ex;
        exp_ex  = exp_q.pop_front();
        #1;
        check("alu_ctrl_e",  32'(ALUCtrlE_o),   32'(exp_ex.alu));
        check("src_a_e",     32'(ALUSrcAE_o),   32'(exp_ex.src_a));
        check("src_b_e",     32'(ALUSrcBE_o),   32'(exp_ex.src_b));
        check("jalr_e",      32'(JalrE_o),      32'(exp_ex.jalr));
        check("load_e",      32'(LoadE_o),      32'(exp_ex.load));
        check("reg_write_e", 32'(RegWriteE_o),  32'(exp_ex.reg_write));
        check("illegal_e",   32'(IllegalE_o),   32'(exp_ex.illegal));
        check("mem_write_m", 32'(MemWriteM_o),  32'(exp_mem.mem_write));
        check("mem_type_m",  32'(MemTypeM_o),   32'(exp_mem.mem_type));
        check("mem_sign_m",  32'(MemSignM_o),   32'(exp_mem.mem_sign));
        check("reg_write_m", 32'(RegWriteM_o),  32'(exp_mem.reg_write));
        check("reg_write_w", 32'(RegWriteW_o),  32'(exp_wb.reg_write));
        check("result_src_w",32'(ResultSrcW_o), 32'(exp_wb.result_src));
        check("retire_cnt",  32'(RetireCnt_o),  32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"},   32'(ALUCtrlE_o),   0);
        check({tag, "_srca"},  32'(ALUSrcAE_o),   0);
        check({tag, "_srcb"},  32'(ALUSrcBE_o),   0);
        check({tag, "_jalr"},  32'(JalrE_o),      0);
        check({tag, "_pcsrc"}, 32'(PCSrcE_o),     0);
        check({tag, "_load"},  32'(LoadE_o),      0);
        check({tag, "_rwe"},   32'(RegWriteE_o),  0);
        check({tag, "_mw"},    32'(MemWriteM_o),  0);
        check({tag, "_mt"},    32'(MemTypeM_o),   0);
        check({tag, "_ms"},    32'(MemSignM_o),   0);
        check({tag, "_rwm"},   32'(RegWriteM_o),  0);
        check({tag, "_rs"},    32'(ResultSrcW_o), 0);
        check({tag, "_rww"},   32'(RegWriteW_o),  0);
        check({tag, "_ill"},   32'(IllegalE_o),   0);
        check({tag, "_cnt"},   32'(RetireCnt_o),  0);
    endtask

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_LHU   = 32'h0000D283;
    localparam logic [31:0] I_SW    = 32'h0050A023;
    localparam logic [31:0] I_SB    = 32'h00508023;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_SUB   = 32'h403100B3;
    localparam logic [31:0] I_SRA   = 32'h403150B3;
    localparam logic [31:0] I_SRAI  = 32'h40115093;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BGE   = 32'h0020D063;
    localparam logic [31:0] I_BLTU  = 32'h0020E063;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_DIVX  = 32'h023140B3;
    localparam logic [31:0] I_LDBAD = 32'h0000B283;
    localparam logic [31:0] I_SLLIB = 32'h40111093;
    localparam logic [31:0] I_SUBX  = 32'h403140B3;

    initial begin
        bub_c   = '0;
        ill_c   = '0; ill_c.illegal = 1'b1;
        add_c   = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000);
        addi_c  = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 4'b0000);
        lw_c    = c(1, 2'b01, 0, 2'b00, 0, 1, 0, 0, 1, 4'b0000);
        lhu_c   = c(1, 2'b01, 0, 2'b10, 1, 1, 0, 0, 1, 4'b0000);
        sw_c    = c(0, 2'b00, 1, 2'b00, 0, 0, 0, 0, 1, 4'b0000);
        sb_c    = c(0, 2'b00, 1, 2'b01, 0, 0, 0, 0, 1, 4'b0000);
        br_c    = c(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0001);
        jal_c   = c(1, 2'b10, 0, 2'b00, 0, 0, 0, 1, 1, 4'b0000);
        jalr_c  = c(1, 2'b10, 0, 2'b00, 0, 0, 1, 0, 1, 4'b0000);
        lui_c   = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 4'b1010);
        auipc_c = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 4'b0000);
        sub_c   = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0001);
        sra_c   = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 4'b1001);
        srai_c  = c(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 4'b1001);
        reset_model();

        // Reset state
        #3 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Timing of a single add through all stages
        step(I_ADD, 1, 0, 3'b000, add_c);
        repeat (4) step(32'h0, 0, 0, 3'b000, bub_c);

        // Loads, stores and the remaining opcodes
        step(I_ADDI,  1, 0, 3'b000, addi_c);
        step(I_LW,    1, 0, 3'b000, lw_c);
        step(I_LHU,   1, 0, 3'b000, lhu_c);
        step(I_SW,    1, 0, 3'b001, sw_c);
        step(I_SB,    1, 0, 3'b001, sb_c);
        step(I_LUI,   1, 0, 3'b011, lui_c);
        step(I_AUIPC, 1, 0, 3'b011, auipc_c);
        step(I_SUB,   1, 0, 3'b000, sub_c);
        step(I_SRA,   1, 0, 3'b000, sra_c);
        step(I_SRAI,  1, 0, 3'b000, srai_c);

        // jalr redirects and the following slot is flushed
        step(I_JALR, 1, 0, 3'b000, jalr_c);
        check("pcsrc_jalr", 32'(PCSrcE_o), 1);
        step(I_ADD, 1, 0, 3'b000, bub_c);
        // jal redirect with an overlapping FlushE_i gives one bubble only
        step(I_JAL, 1, 0, 3'b100, jal_c);
        check("pcsrc_jal", 32'(PCSrcE_o), 1);
        step(I_ADD, 1, 1, 3'b000, bub_c);
        step(I_ADD, 1, 0, 3'b000, add_c);

        // Illegal encodings and the M-extension instance
        step(I_BAD,   1, 0, 3'b000, ill_c);
        step(I_DIVX,  1, 0, 3'b000, ill_c);
        check("m_ext_alu", 32'(alu_mx), 32'h14);
        check("m_ext_ill", 32'(ill_mx), 0);
        step(I_LDBAD, 1, 0, 3'b000, ill_c);
        step(I_SLLIB, 1, 0, 3'b000, ill_c);
        step(I_SUBX,  1, 0, 3'b000, ill_c);
        step(I_ADD,   0, 0, 3'b000, bub_c);
        step(I_ADD,   1, 1, 3'b000, bub_c);
        repeat (3) step(32'h0, 0, 0, 3'b000, bub_c);

        // bge not-less-than is taken, so the next valid slot becomes a bubble
        step(I_BGE, 1, 0, 3'b010, br_c);
        LtE_i = 1'b0;
        #1 check("pcsrc_bge", 32'(PCSrcE_o), 1);
        step(I_ADD, 1, 0, 3'b000, bub_c);
        // bltu with Ltu=0 is not taken
        step(I_BLTU, 1, 0, 3'b010, br_c);
        LtuE_i = 1'b0;
        #1 check("pcsrc_bltu", 32'(PCSrcE_o), 0);
        step(I_ADD, 1, 0, 3'b000, add_c);

        // All six branch conditions against all flag combinations
        for (int f = 0; f < 8; f++) begin
            logic [31:0] bi;
            logic [2:0]  f3;
            if (f == 2 || f == 3) continue;
            f3 = f[2:0];
            bi = I_BEQ | (32'(f3) << 12);
            {ZeroE_i, LtE_i, LtuE_i} = 3'b000;
            step(bi, 1, 0, 3'b010, br_c);
            for (int fl = 0; fl < 8; fl++) begin
                logic [2:0] fb;
                logic       t;
                fb = fl[2:0];
                {ZeroE_i, LtE_i, LtuE_i} = fb;
                case (f3)
                    3'b000:  t = fb[2];
                    3'b001:  t = !fb[2];
                    3'b100:  t = fb[1];
                    3'b101:  t = !fb[1];
                    3'b110:  t = fb[0];
                    default: t = !fb[0];
                endcase
                #1 check("pcsrc_sweep", 32'(PCSrcE_o), 32'(t));
            end
            step(32'h0, 0, 0, 3'b000, bub_c);
        end
        {ZeroE_i, LtE_i, LtuE_i} = 3'b000;

        // Reset with add/lw/sw in flight
        step(I_ADD, 1, 0, 3'b000, add_c);
        step(I_LW,  1, 0, 3'b000, lw_c);
        step(I_SW,  1, 0, 3'b001, sw_c);
        rst_n = 1'b0;
        ValidD_i = 1'b0;
        #1 check_all_zero("midreset");
        reset_model();
        @(negedge clk) rst_n = 1'b1;

        // Counter wrap with a 4-bit counter
        repeat (17) step(I_ADDI, 1, 0, 3'b000, addi_c);
        repeat (3) step(32'h0, 0, 0, 3'b000, bub_c);
        check("retire_wrap", 32'(RetireCnt_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
